// File: rtl/mapper_megaram_multi.sv
// Multi-instance MegaRAM/MegaROM mapper sharing one RAM port.
// ASCII8K / ASCII16K / Konami-SCC bank decode, req/ack RAM FSM with timeout.
module mapper_megaram_multi #(
  parameter int SLOTS   = 2,
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ID_W-1:0]   inst_id,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        bank_mask,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_req,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic              cpu_wait,
  output logic              scc_en,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rnw,
  output logic              timeout_err
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [1:0]  M_OFF = 2'b00;
  localparam logic [1:0]  M_A8  = 2'b01;
  localparam logic [1:0]  M_SCC = 2'b10;
  localparam logic [1:0]  M_A16 = 2'b11;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_e              state_q, state_d;
  logic [7:0]          bank_q [SLOTS][4];
  logic [15:0]         cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                rnw_q, rnw_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                id_ok, active, idle, busy;
  logic [ID_W-1:0]     sel;
  logic [2:0]          pg;
  logic [1:0]          pidx;
  logic                in_win;
  logic [7:0]          cur, b2;
  logic                scc_win, rd_hit, wr_hit, hit;
  logic                rw, a8_we, a16_we, scc_we;
  logic [ADDR_W-1:0]   lin;

  assign id_ok  = 32'(inst_id) < 32'(SLOTS);
  assign sel    = id_ok ? inst_id : '0;
  assign active = id_ok && (mode != M_OFF);
  assign idle   = (state_q == IDLE);
  assign busy   = (state_q == ACCESS);

  assign pg     = cpu_addr[15:13];
  assign pidx   = {pg[2], pg[0]};
  assign in_win = (pg >= 3'd2) && (pg <= 3'd5);
  assign cur    = bank_q[sel][pidx];
  assign b2     = bank_q[sel][2];

  assign scc_win = active && (mode == M_SCC)
                && (cpu_addr[15:11] == 5'b10011)
                && (b2[5:0] == 6'h3f);
  assign scc_en  = scc_win && (cpu_req || busy);

  assign rd_hit = cpu_rd && in_win && !scc_win;
  assign wr_hit = cpu_wr && mode[0] && in_win
               && (pg != 3'b011) && cur[7];
  assign hit    = active && cpu_req && idle
               && (rd_hit || wr_hit);

  assign cpu_wait = busy || hit;

  assign rw     = active && cpu_req && cpu_wr && idle;
  assign a8_we  = rw && (mode == M_A8) && (pg == 3'b011);
  assign a16_we = rw && (mode == M_A16) && (pg == 3'b011)
               && !cpu_addr[11];
  assign scc_we = rw && (mode == M_SCC) && in_win
               && (cpu_addr[12:11] == 2'b10);

  assign lin = base_addr
             + ADDR_W'({cur & bank_mask, 13'h0})
             + ADDR_W'(cpu_addr[12:0]);

  // Bank registers: mapper-specific register write decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++)
        for (int j = 0; j < 4; j++)
          bank_q[i][j] <= 8'(j);
    end else if (a8_we) begin
      bank_q[sel][cpu_addr[12:11]] <= cpu_data;
    end else if (a16_we) begin
      bank_q[sel][{cpu_addr[12], 1'b0}] <=
        {cpu_data[7], cpu_data[5:0], 1'b0};
      bank_q[sel][{cpu_addr[12], 1'b1}] <=
        {cpu_data[7], cpu_data[5:0], 1'b1};
    end else if (scc_we) begin
      bank_q[sel][pidx] <= cpu_data;
    end
  end

  // RAM handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      rnw_q   <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  // RAM handshake next state: launch, ack, timeout abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rnw_d   = rnw_q;
    err_d   = err_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          addr_d  = lin;
          rnw_d   = ~cpu_wr;
          cnt_d   = 16'd1;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (cnt_q >= TO_LIM) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_req     = req_q;
  assign ram_addr    = addr_q;
  assign ram_rnw     = rnw_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mapper_megaram_multi.sv
// Bench for mapper_megaram_multi: scoreboarded RAM requests,
// per-feature tasks checking stalls, SCC window, banks and timeout.
module tb_mapper_megaram_multi;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [0:0]    inst_id = '0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    bank_mask = 8'hff;
  logic [15:0]   cpu_addr = '0;
  logic [7:0]    cpu_data = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic          ram_ack = 1'b0;
  logic          cpu_wait, scc_en, ram_req, ram_rnw, timeout_err;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  logic [AW:0]   exp_q[$];
  logic [AW:0]   e;
  logic [AW:0]   lat;
  bit            seen = 0;
  bit            ack_en = 1;
  int            ack_dly = 1;
  int            acnt = 0;
  int            req_cyc = 0;

  mapper_megaram_multi #(
    .SLOTS(2), .ADDR_W(AW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .inst_id(inst_id),
    .mode(mode), .base_addr(base_addr),
    .bank_mask(bank_mask), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_req(cpu_req),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wait(cpu_wait), .scc_en(scc_en),
    .ram_req(ram_req), .ram_ack(ram_ack),
    .ram_addr(ram_addr), .ram_rnw(ram_rnw),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RAM side model: scoreboard pop on new request, ack after ack_dly
  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 0;
      ram_ack = 1'b0;
    end else if (ram_req) begin
      checks++;
      if (!seen) begin
        seen = 1;
        acnt = 0;
        req_cyc = 0;
        lat = {ram_rnw, ram_addr};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ram_unexpected got rnw=%0b addr=%h",
                   ram_rnw, ram_addr);
        end else begin
          e = exp_q.pop_front();
          if ({ram_rnw, ram_addr} !== e) begin
            errors++;
            $display("FAIL ram_req got rnw=%0b addr=%h exp rnw=%0b addr=%h",
                     ram_rnw, ram_addr, e[AW], e[AW-1:0]);
          end
        end
      end else if ({ram_rnw, ram_addr} !== lat) begin
        errors++;
        $display("FAIL ram_stable got %h exp %h",
                 {ram_rnw, ram_addr}, lat);
      end
      acnt++;
      req_cyc++;
      ram_ack = ack_en && (acnt >= ack_dly);
    end else begin
      seen = 0;
      ram_ack = 1'b0;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ack_en = 1;
    ack_dly = 1;
  endtask

  task automatic cpu_op(input logic wr, input logic [15:0] a,
                        input logic [7:0] d,
                        output int waits, output logic scc);
    @(negedge clk);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr = wr;
    cpu_rd = ~wr;
    cpu_req = 1'b1;
    #1;
    waits = cpu_wait ? 1 : 0;
    scc = scc_en;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    #1;
    for (int n = 0; n < 300 && cpu_wait; n++) begin
      waits++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks += 6;
    if (ram_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b exp 0", ram_req);
    end
    if (ram_addr !== '0) begin
      errors++; $display("FAIL rst_addr got %h exp 0", ram_addr);
    end
    if (ram_rnw !== 1'b1) begin
      errors++; $display("FAIL rst_rnw got %b exp 1", ram_rnw);
    end
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b exp 0", timeout_err);
    end
    if (cpu_wait !== 1'b0) begin
      errors++; $display("FAIL rst_wait got %b exp 0", cpu_wait);
    end
    if (scc_en !== 1'b0) begin
      errors++; $display("FAIL rst_scc got %b exp 0", scc_en);
    end
    do_reset();
  endtask

  task automatic test_defaults();
    int w; logic s;
    inst_id = 0; mode = 2'b01; base_addr = '0; bank_mask = 8'hff;
    ack_dly = 3;
    exp_q.push_back({1'b1, 27'h0004000});
    cpu_op(1'b0, 16'h8000, 8'h00, w, s);
    checks++;
    if (w !== 4) begin
      errors++; $display("FAIL dflt_wait got %0d exp 4", w);
    end
  endtask

  task automatic test_asc16k();
    int w; logic s;
    mode = 2'b11; ack_dly = 1;
    cpu_op(1'b1, 16'h7000, 8'hc5, w, s);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL a16_regwr_wait got %0d exp 0", w);
    end
    exp_q.push_back({1'b0, 27'h0116123});
    cpu_op(1'b1, 16'ha123, 8'h55, w, s);
    checks++;
    if (w !== 2) begin
      errors++; $display("FAIL a16_wr_wait got %0d exp 2", w);
    end
    exp_q.push_back({1'b0, 27'h0114010});
    cpu_op(1'b1, 16'h8010, 8'h66, w, s);
    cpu_op(1'b1, 16'h6000, 8'h05, w, s);
    cpu_op(1'b1, 16'h4000, 8'h11, w, s);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL a16_wen_off_wait got %0d exp 0", w);
    end
    exp_q.push_back({1'b1, 27'h0014000});
    cpu_op(1'b0, 16'h4000, 8'h00, w, s);
    exp_q.push_back({1'b1, 27'h0016000});
    cpu_op(1'b0, 16'h6000, 8'h00, w, s);
  endtask

  task automatic test_scc();
    int w; logic s;
    do_reset();
    mode = 2'b10; base_addr = 27'h0100000; bank_mask = 8'hff;
    cpu_op(1'b1, 16'h9000, 8'h3f, w, s);
    cpu_op(1'b0, 16'h9810, 8'h00, w, s);
    checks += 2;
    if (s !== 1'b1) begin
      errors++; $display("FAIL scc_win_en got %b exp 1", s);
    end
    if (w !== 0) begin
      errors++; $display("FAIL scc_win_wait got %0d exp 0", w);
    end
    exp_q.push_back({1'b1, 27'h017e810});
    cpu_op(1'b0, 16'h8810, 8'h00, w, s);
    checks += 2;
    if (s !== 1'b0) begin
      errors++; $display("FAIL scc_ram_en got %b exp 0", s);
    end
    if (w !== 2) begin
      errors++; $display("FAIL scc_ram_wait got %0d exp 2", w);
    end
    cpu_op(1'b1, 16'h8000, 8'haa, w, s);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL scc_wr_wait got %0d exp 0", w);
    end
  endtask

  task automatic test_two_inst();
    int w; logic s;
    do_reset();
    inst_id = 0; mode = 2'b01; base_addr = '0; bank_mask = 8'hff;
    cpu_op(1'b1, 16'h6800, 8'h07, w, s);
    inst_id = 1; base_addr = 27'h0200000;
    exp_q.push_back({1'b1, 27'h0202000});
    cpu_op(1'b0, 16'h6000, 8'h00, w, s);
    inst_id = 0; base_addr = '0;
    exp_q.push_back({1'b1, 27'h000e000});
    cpu_op(1'b0, 16'h6000, 8'h00, w, s);
  endtask

  task automatic test_wrap();
    int w; logic s;
    inst_id = 0; mode = 2'b01;
    bank_mask = 8'h0f; base_addr = 27'h7fff000;
    cpu_op(1'b1, 16'h7800, 8'h13, w, s);
    exp_q.push_back({1'b1, 27'h0005010});
    cpu_op(1'b0, 16'ha010, 8'h00, w, s);
    mode = 2'b00;
    cpu_op(1'b0, 16'h8000, 8'h00, w, s);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL off_wait got %0d exp 0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w; logic s;
    do_reset();
    inst_id = 0; mode = 2'b01; base_addr = '0; bank_mask = 8'hff;
    ack_dly = 3;
    exp_q.push_back({1'b1, 27'h0004000});
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_rd = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    cpu_addr = 16'h6800; cpu_data = 8'h55;
    cpu_rd = 1'b0; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    #1;
    for (int n = 0; n < 50 && cpu_wait; n++) begin
      @(negedge clk);
      #1;
    end
    ack_dly = 1;
    exp_q.push_back({1'b1, 27'h0002000});
    cpu_op(1'b0, 16'h6000, 8'h00, w, s);
    exp_q.push_back({1'b1, 27'h0006004});
    cpu_op(1'b0, 16'ha004, 8'h00, w, s);
    checks++;
    if (w !== 2) begin
      errors++; $display("FAIL b2b_wait got %0d exp 2", w);
    end
  endtask

  task automatic test_timeout();
    int w; logic s;
    do_reset();
    inst_id = 0; mode = 2'b01; base_addr = '0; bank_mask = 8'hff;
    ack_dly = 4;
    exp_q.push_back({1'b1, 27'h0004000});
    cpu_op(1'b0, 16'h8000, 8'h00, w, s);
    checks += 2;
    if (w !== 5) begin
      errors++; $display("FAIL to_edge_wait got %0d exp 5", w);
    end
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_edge_err got %b exp 0", timeout_err);
    end
    ack_en = 0;
    exp_q.push_back({1'b1, 27'h0004000});
    cpu_op(1'b0, 16'h8000, 8'h00, w, s);
    checks += 3;
    if (w !== 5) begin
      errors++; $display("FAIL to_wait got %0d exp 5", w);
    end
    if (req_cyc !== 4) begin
      errors++; $display("FAIL to_req_cycles got %0d exp 4", req_cyc);
    end
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_err got %b exp 1", timeout_err);
    end
    ack_en = 1; ack_dly = 1;
    exp_q.push_back({1'b1, 27'h0006000});
    cpu_op(1'b0, 16'ha000, 8'h00, w, s);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky got %b exp 1", timeout_err);
    end
    ack_en = 0;
    exp_q.push_back({1'b1, 27'h0004000});
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_rd = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (ram_req !== 1'b0) begin
      errors++; $display("FAIL mid_rst_req got %b exp 0", ram_req);
    end
    if (cpu_wait !== 1'b0) begin
      errors++; $display("FAIL mid_rst_wait got %b exp 0", cpu_wait);
    end
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_err got %b exp 0", timeout_err);
    end
    if (ram_addr !== '0) begin
      errors++; $display("FAIL mid_rst_addr got %h exp 0", ram_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_en = 1;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_asc16k();
    test_scc();
    test_two_inst();
    test_wrap();
    test_back_to_back();
    test_timeout();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
